// File: rtl/rv_isa_pkg.sv
// RV32I encoding definitions shared by the encoder, the decoder and the decode self-check.
// Holds the format codes, the opcode constants and the decoded field bundle.
package rv_isa_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
    } fields_t;

    // True when imm[31:msb] are all copies of one bit, i.e. the value fits a signed field of msb+1 bits.
    function automatic logic imm_fits(input logic [31:0] imm, input int unsigned msb);
        logic [31:0] upper;
        upper = 32'($signed(imm) >>> msb);
        return (upper == '0) || (upper == '1);
    endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational RV32I packer: decoded fields plus format select in, instruction word and
// immediate-range/format error out. Shared with the decode self-check.
module inst_pack
    import rv_isa_pkg::*;
(
    input  fields_t     fields,
    output logic [31:0] inst,
    output logic        err
);

    logic [31:0] imm;
    assign imm = fields.imm;

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        inst = '0;
        err  = 1'b0;
        case (fields.fmt)
            FMT_R: begin
                inst = {fields.funct7, fields.rs2, fields.rs1, fields.funct3, fields.rd, fields.opcode};
            end
            FMT_I: begin
                inst = {imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
                err  = !imm_fits(imm, 11);
            end
            FMT_S: begin
                inst = {imm[11:5], fields.rs2, fields.rs1, fields.funct3, imm[4:0], fields.opcode};
                err  = !imm_fits(imm, 11);
            end
            FMT_B: begin
                inst = {imm[12], imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                        imm[4:1], imm[11], fields.opcode};
                err  = !imm_fits(imm, 12) || imm[0];
            end
            FMT_U: begin
                inst = {imm[31:12], fields.rd, fields.opcode};
                err  = |imm[11:0];
            end
            FMT_J: begin
                inst = {imm[20], imm[10:1], imm[11], imm[19:12], fields.rd, fields.opcode};
                err  = !imm_fits(imm, 20) || imm[0];
            end
            default: begin
                // Illegal format: zero word, always flagged.
                inst = '0;
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/inst_encode.sv
// Two-stage valid/ready RV32I encoder: S1 holds the raw field bundle, S2 holds the packed
// word and its error flag; err_cnt counts delivered error words, saturating.
module inst_encode
    import rv_isa_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic [15:0] err_cnt
);

    fields_t     in_fields;
    fields_t     s1_q, s1_d;
    logic        s1_v_q, s1_v_d;
    logic [31:0] s2_inst_q, s2_inst_d;
    logic        s2_err_q, s2_err_d;
    logic        s2_v_q, s2_v_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [31:0] pack_inst;
    logic        pack_err;
    logic        s2_load;
    logic        s1_load;

    assign in_fields = '{fmt: in_fmt, opcode: in_opcode, funct3: in_funct3, funct7: in_funct7,
                         rs1: in_rs1, rs2: in_rs2, rd: in_rd, imm: in_imm};

    inst_pack u_pack (
        .fields (s1_q),
        .inst   (pack_inst),
        .err    (pack_err)
    );

    // S1 may refill whenever it is empty or its word moves on into S2 this edge.
    assign s2_load  = !s2_v_q || out_ready;
    assign s1_load  = !s1_v_q || s2_load;
    assign in_ready = s1_load;

    always_comb begin
        s1_d      = s1_q;
        s1_v_d    = s1_v_q;
        s2_inst_d = s2_inst_q;
        s2_err_d  = s2_err_q;
        s2_v_d    = s2_v_q;
        err_cnt_d = err_cnt_q;

        if (s1_load) begin
            s1_v_d = in_valid;
            if (in_valid) s1_d = in_fields;
        end
        if (s2_load) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_inst_d = pack_inst;
                s2_err_d  = pack_err;
            end
        end
        if (s2_v_q && out_ready && s2_err_q && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= '0;
            s1_v_q    <= 1'b0;
            s2_inst_q <= '0;
            s2_err_q  <= 1'b0;
            s2_v_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            s1_q      <= s1_d;
            s1_v_q    <= s1_v_d;
            s2_inst_q <= s2_inst_d;
            s2_err_q  <= s2_err_d;
            s2_v_q    <= s2_v_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out_inst  = s2_inst_q;
    assign out_err   = s2_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_inst_encode.sv
// Directed bench for inst_encode: hand-computed RV32I words, error cases, backpressure
// and asynchronous reset with both stages full.
module tb_inst_encode;
    import rv_isa_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic [15:0] err_cnt;

    int tests = 0;
    int fails = 0;

    inst_encode dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rd     (in_rd),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] imm);
        in_fmt    = fmt;
        in_opcode = op;
        in_funct3 = f3;
        in_funct7 = f7;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_rd     = rd;
        in_imm    = imm;
        in_valid  = 1'b1;
    endtask

    task automatic check_word(input string tag, input logic [31:0] inst, input logic err);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_inst"}, out_inst, inst);
        check({tag, "_err"}, 32'(out_err), 32'(err));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(3'(FMT_R), OP, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        in_valid  = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // addi x1,x0,5: one cycle after acceptance
        drive(3'(FMT_I), OP_IMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
        tick();
        in_valid = 1'b0;
        check("i_latency_gap", 32'(out_valid), 32'd0);
        tick();
        check_word("i_addi", 32'h00500093, 1'b0);
        tick();
        check("i_drained", 32'(out_valid), 32'd0);

        // R, S, B back to back with three consecutive output cycles
        drive(3'(FMT_R), OP, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        tick();
        check("rsb_gap", 32'(out_valid), 32'd0);
        drive(3'(FMT_S), OP_STORE, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8);
        tick();
        check_word("r_add", 32'h002081B3, 1'b0);
        drive(3'(FMT_B), OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC);
        tick();
        in_valid = 1'b0;
        check_word("s_sw", 32'h0020A423, 1'b0);
        tick();
        check_word("b_beq", 32'hFE000EE3, 1'b0);
        tick();
        check("rsb_drained", 32'(out_valid), 32'd0);

        // U and J
        drive(3'(FMT_U), OP_LUI, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'h12345000);
        tick();
        drive(3'(FMT_J), OP_JAL, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd8);
        tick();
        in_valid = 1'b0;
        check_word("u_lui", 32'h123452B7, 1'b0);
        tick();
        check_word("j_jal", 32'h008000EF, 1'b0);
        tick();
        check("err_cnt_clean", 32'(err_cnt), 32'd0);

        // Error words still carry the truncated packing and are delivered
        drive(3'(FMT_I), OP_IMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd2048);
        tick();
        drive(3'(FMT_B), OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3);
        tick();
        check_word("err_i_2048", 32'h80000093, 1'b1);
        drive(3'd7, OP_IMM, 3'd1, 7'd1, 5'd1, 5'd1, 5'd1, 32'd1);
        tick();
        in_valid = 1'b0;
        check_word("err_b_odd", 32'h00000163, 1'b1);
        check("err_cnt_1", 32'(err_cnt), 32'd1);
        tick();
        check_word("err_fmt7", 32'h00000000, 1'b1);
        check("err_cnt_2", 32'(err_cnt), 32'd2);
        tick();
        check("err_cnt_3", 32'(err_cnt), 32'd3);
        check("err_drained", 32'(out_valid), 32'd0);

        // Backpressure: two bundles held, third stalls until release
        out_ready = 1'b0;
        drive(3'(FMT_I), OP_IMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd1);
        #1;
        check("bp_ready_a", 32'(in_ready), 32'd1);
        tick();
        drive(3'(FMT_I), OP_IMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd2, 32'd2);
        tick();
        drive(3'(FMT_I), OP_IMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd3, 32'd3);
        #1;
        check("bp_full_ready", 32'(in_ready), 32'd0);
        check_word("bp_hold_a0", 32'h00100093, 1'b0);
        tick();
        check("bp_still_full", 32'(in_ready), 32'd0);
        check_word("bp_hold_a1", 32'h00100093, 1'b0);
        tick();
        check_word("bp_hold_a2", 32'h00100093, 1'b0);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check_word("bp_word_b", 32'h00200113, 1'b0);
        tick();
        check_word("bp_word_c", 32'h00300193, 1'b0);
        tick();
        check("bp_drained", 32'(out_valid), 32'd0);
        check("bp_err_cnt", 32'(err_cnt), 32'd3);

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        drive(3'd6, OP, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        tick();
        drive(3'(FMT_I), OP_IMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd4, 32'd4);
        tick();
        in_valid = 1'b0;
        check("mid_full_ready", 32'(in_ready), 32'd0);
        check_word("mid_full_word", 32'h00000000, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_err_cnt", 32'(err_cnt), 32'd3 - 32'd3);
        check("mid_rst_inst", out_inst, 32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_rst_no_stale%0d", i), 32'(out_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
